seq_det_stream_ctrl: RTL and testbench

- Streams parallel words into a serial 1011 pattern detector and reports per-word match counts.
- Accepts WORD_W-bit words on a valid/ready input and shifts them MSB-first into an embedded overlapping-1011 detector core, one bit per clock.
- Returns a per-word match count on a valid/ready output and keeps a saturating running total.
- Sits between a word-oriented producer and the bit-serial detection logic.

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_1011_core.sv | 40 ++++
 rtl/seq_det_stream_ctrl.sv | 120 ++++++++++++
 tb/tb_seq_det_stream_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared encodings for the 1011 stream detector: core states, controller
// states and the pattern being searched for.
package seq_det_pkg;

    localparam logic [1:0] CORE_A = 2'b00;
    localparam logic [1:0] CORE_B = 2'b01;
    localparam logic [1:0] CORE_C = 2'b10;
    localparam logic [1:0] CORE_D = 2'b11;

    localparam logic [1:0] CTRL_IDLE   = 2'b00;
    localparam logic [1:0] CTRL_SHIFT  = 2'b01;
    localparam logic [1:0] CTRL_REPORT = 2'b10;

    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_1011_core.sv
// Bit-serial Mealy detector for overlapping occurrences of PATTERN (1011).
// State only moves on bit_en, so it holds context between words.
module seq_1011_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic bit_en,
    input  logic bit_in,
    output logic tick
);

    logic [1:0] state_q, state_d;

    // Each state remembers the longest pattern prefix that is a suffix of the input.
    always_comb begin
        state_d = state_q;
        if (bit_en) begin
            case (state_q)
                CORE_A:  state_d = (bit_in == PATTERN[3]) ? CORE_B : CORE_A;
                CORE_B:  state_d = (bit_in == PATTERN[2]) ? CORE_C : CORE_B;
                CORE_C:  state_d = (bit_in == PATTERN[1]) ? CORE_D : CORE_A;
                CORE_D:  state_d = (bit_in == PATTERN[0]) ? CORE_B : CORE_C;
                default: state_d = CORE_A;
            endcase
        end
    end

    assign tick = bit_en && (state_q == CORE_D) && (bit_in == PATTERN[0]);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state_q <= CORE_A;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Word-to-bit controller: serialises each accepted word MSB-first into the
// 1011 core, then reports the per-word match count and a saturating total.
module seq_det_stream_ctrl
    import seq_det_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4,   // 2**CNT_W must exceed WORD_W
    parameter int TOT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              keep_ctx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_hit,
    output logic [TOT_W-1:0]  total_count,
    input  logic              clr_total,
    output logic              busy
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [TOT_W-1:0] TOTAL_MAX = {TOT_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TOT_W-1:0]  total_q, total_d;

    logic accept;
    logic core_clr;
    logic bit_en;
    logic tick;

    assign accept   = in_valid && (state_q == CTRL_IDLE);
    assign core_clr = accept && !keep_ctx;
    assign bit_en   = (state_q == CTRL_SHIFT);

    seq_1011_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (core_clr),
        .bit_en (bit_en),
        .bit_in (shift_q[WORD_W-1]),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        count_d = count_q;
        case (state_q)
            CTRL_IDLE: begin
                if (accept) begin
                    shift_d = in_data;
                    idx_d   = IDX_W'(WORD_W - 1);
                    count_d = '0;
                    state_d = CTRL_SHIFT;
                end
            end
            CTRL_SHIFT: begin
                shift_d = shift_q << 1;
                if (tick) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (idx_q == '0) begin
                    state_d = CTRL_REPORT;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            CTRL_REPORT: begin
                // Returning to IDLE guarantees at least one idle cycle between words.
                if (out_ready) begin
                    state_d = CTRL_IDLE;
                end
            end
            default: state_d = CTRL_IDLE;
        endcase
    end

    // Clear beats a coincident tick; the total sticks at its maximum.
    always_comb begin
        total_d = total_q;
        if (clr_total) begin
            total_d = '0;
        end else if (tick && (total_q != TOTAL_MAX)) begin
            total_d = total_q + TOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CTRL_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            count_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            total_q <= total_d;
        end
    end

    assign in_ready    = (state_q == CTRL_IDLE);
    assign out_valid   = (state_q == CTRL_REPORT);
    assign out_count   = count_q;
    assign out_hit     = (count_q != '0);
    assign total_count = total_q;
    assign busy        = (state_q != CTRL_IDLE);

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Directed scoreboard bench for seq_det_stream_ctrl; a second instance with a
// 2-bit total exercises saturation on the same stimulus.
module tb_seq_det_stream_ctrl;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;
    localparam int TOT_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              keep_ctx;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_hit;
    logic [TOT_W-1:0]  total_count;
    logic              clr_total;
    logic              busy;

    logic              sat_in_ready;
    logic              sat_out_valid;
    logic [CNT_W-1:0]  sat_out_count;
    logic              sat_out_hit;
    logic [1:0]        sat_total;
    logic              sat_busy;

    seq_det_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .keep_ctx    (keep_ctx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .out_hit     (out_hit),
        .total_count (total_count),
        .clr_total   (clr_total),
        .busy        (busy)
    );

    seq_det_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W), .TOT_W(2)) u_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (sat_in_ready),
        .in_data     (in_data),
        .keep_ctx    (keep_ctx),
        .out_valid   (sat_out_valid),
        .out_ready   (out_ready),
        .out_count   (sat_out_count),
        .out_hit     (sat_out_hit),
        .total_count (sat_total),
        .clr_total   (clr_total),
        .busy        (sat_busy)
    );

    typedef struct {
        int cnt;
        int tot;
        int sat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: a match is the last four bits seen since restart equal 1011.
    logic [3:0] hist = 4'b0000;
    int         hlen = 0;
    int         exp_total = 0;
    int         exp_sat   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w, input logic kc, input int clr_k);
        exp_t e;
        int   c = 0;
        logic hit;
        if (!kc) hlen = 0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            hist = {hist[2:0], w[i]};
            if (hlen < 4) hlen++;
            hit = (hlen >= 4) && (hist == 4'b1011);
            if (hit) c++;
            if (clr_k == WORD_W - i) begin
                exp_total = 0;
                exp_sat   = 0;
            end else if (hit) begin
                if (exp_total < 65535) exp_total++;
                if (exp_sat < 3) exp_sat++;
            end
        end
        e.cnt = c;
        e.tot = exp_total;
        e.sat = exp_sat;
        sb.push_back(e);
    endtask

    // clr_k > 0 pulses clr_total during the clr_k-th bit-scan cycle of this word.
    task automatic send(input logic [WORD_W-1:0] w, input logic kc, input int clr_k);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", {31'b0, in_ready}, 1);
            return;
        end
        push_word(w, kc, clr_k);
        in_valid = 1'b1;
        in_data  = w;
        keep_ctx = kc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (clr_k > 0) begin
            repeat (clr_k - 1) @(posedge clk);
            #1 clr_total = 1'b1;
            @(posedge clk); #1;
            clr_total = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_busy", {31'b0, busy}, 0);
        chk("drain_pending", sb.size(), 0);
    endtask

    // Output monitor: compares each handed-off result with the scoreboard head.
    int   acc_cyc   = 0;
    int   first_cyc = 0;
    logic prev_ov   = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acc_cyc = cyc;
            if (out_valid && !prev_ov) first_cyc = cyc;
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {31'b0, out_valid}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    $display("word result: count=%0d hit=%0b total=%0d sat_total=%0d latency=%0d",
                             out_count, out_hit, total_count, sat_total, first_cyc - acc_cyc);
                    chk("out_count", 32'(out_count), mon_e.cnt);
                    chk("out_hit", {31'b0, out_hit}, (mon_e.cnt != 0) ? 1 : 0);
                    chk("total_count", 32'(total_count), mon_e.tot);
                    chk("sat_total", 32'(sat_total), mon_e.sat);
                    chk("latency", first_cyc - acc_cyc, WORD_W + 1);
                end
            end
        end else begin
            prev_ov = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        keep_ctx  = 1'b0;
        out_ready = 1'b1;
        clr_total = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_out_hit", {31'b0, out_hit}, 0);
        chk("rst_total", 32'(total_count), 0);
        chk("rst_busy", {31'b0, busy}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic and overlapping matches
        send(8'b1011_0000, 1'b0, 0); drain();
        send(8'b1011_0110, 1'b0, 0); drain();

        // Context carried across words, then restarted
        send(8'b0000_0101, 1'b0, 0); drain();
        send(8'b1000_0000, 1'b1, 0); drain();
        send(8'b0000_0101, 1'b0, 0); drain();
        send(8'b1000_0000, 1'b0, 0); drain();

        // clr_total coinciding with the tick on bit index 4
        send(8'b1011_0000, 1'b0, 4); drain();
        chk("clr_total_zero", 32'(total_count), 0);

        // Saturation of the 2-bit total
        for (int k = 0; k < 4; k++) begin
            send(8'b1011_0000, 1'b0, 0); drain();
        end
        chk("sat_stuck", 32'(sat_total), 3);

        // Backpressure: result held, second word waits for the handoff
        out_ready = 1'b0;
        send(8'b1011_0000, 1'b0, 0);
        for (int n = 0; n < 50 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid_seen", {31'b0, out_valid}, 1);
        push_word(8'b1011_0110, 1'b0, 0);
        in_valid = 1'b1;
        in_data  = 8'b1011_0110;
        keep_ctx = 1'b0;
        for (int n = 0; n < 5; n++) begin
            chk("bp_out_valid", {31'b0, out_valid}, 1);
            chk("bp_out_count", 32'(out_count), 1);
            chk("bp_busy", {31'b0, busy}, 1);
            chk("bp_in_ready", {31'b0, in_ready}, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_after_handoff", {31'b0, busy}, 0);
        chk("bp_ready_after_handoff", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        chk("bp_accept_next", {31'b0, busy}, 1);
        in_valid = 1'b0;
        drain();

        // Reset during the third scan cycle discards the word
        send(8'b1010_0000, 1'b0, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        hlen      = 0;
        exp_total = 0;
        exp_sat   = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_total", 32'(total_count), 0);
        chk("mid_rst_count", 32'(out_count), 0);
        repeat (12) @(posedge clk);
        #1;
        chk("mid_rst_no_result", {31'b0, out_valid}, 0);
        send(8'b1100_0000, 1'b1, 0); drain();
        send(8'b1011_0000, 1'b1, 0); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
